if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 400, meaning the instruction memory size in bytes.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-003 SHALL have parameter NOP, default 32'h0000_0000, meaning the bubble instruction word.
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports as listed:
  clk  in  1  clock, rising-edge
  rst  in  1  synchronous active-high reset
  stall  in  1  hazard unit hold request
  br_taken  in  1  branch resolved taken
  br_target  in  32  branch target byte address
  jmp  in  1  jump request
  jmp_target  in  32  jump target byte address
  imem_addr  out  32  byte address to instruction memory (combinational from PC)
  imem_data  in  32  big-endian word returned combinationally by instruction memory
  ifid_instr  out  32  IF/ID registered instruction
  ifid_pc4  out  32  IF/ID registered PC+4
  ifid_valid  out  1  IF/ID contents are a real instruction
  halted  out  1  fetch stopped
  misalign_err  out  1  sticky bad-redirect flag
  fetch_count  out  16  instructions delivered to IF/ID
REQ-005 SHALL drive imem_addr equal to the internal PC register with zero added latency.

Function
REQ-006 SHALL implement a two-state FSM, RUN and HALT; HALT is left only by rst.
REQ-007 SHALL evaluate each RUN-state rising edge with priority rst > redirect (jmp or br_taken) > stall > sequential.
REQ-008 SHALL give jmp priority over br_taken when both are asserted in the same cycle.
REQ-009 Redirect, valid target: PC <= target; IF/ID <= {NOP, 0, valid=0}; fetch_count unchanged; applies even when stall=1.
REQ-010 Valid target SHALL mean target[1:0]==2'b00 and target <= MEM_BYTES-4.
REQ-011 Redirect, target[1:0]!=0: misalign_err <= 1, state <= HALT, PC holds.
REQ-012 Redirect, aligned target > MEM_BYTES-4: state <= HALT, PC holds, misalign_err unchanged.
REQ-013 Stall (no redirect): PC, IF/ID registers and fetch_count SHALL all hold.
REQ-014 Sequential: IF/ID <= {imem_data, PC+4, valid=1}; fetch_count += 1.
REQ-015 Sequential, PC+4 <= MEM_BYTES-4: PC <= PC+4.
REQ-016 Sequential, PC+4 > MEM_BYTES-4: PC holds and state <= HALT; the last word is still delivered in that cycle.
REQ-017 fetch_count SHALL saturate at 16'hFFFF with no wrap.
REQ-018 In HALT: halted=1; ifid_valid <= 0; ifid_instr <= NOP; PC and fetch_count hold; stall, jmp and br_taken are ignored.
REQ-019 All PC and PC+4 arithmetic SHALL be 32-bit unsigned; no overflow occurs given REQ-010.
REQ-020 All outputs except imem_addr SHALL be registered.

Reset
REQ-021 On rst at a rising edge, regardless of state or other inputs: PC <= RESET_PC, state <= RUN, ifid_instr <= NOP, ifid_pc4 <= 0, ifid_valid <= 0, halted <= 0, misalign_err <= 0, fetch_count <= 0.
REQ-022 Reset asserted mid-stall or mid-redirect SHALL take effect in that same cycle, overriding both.
REQ-023 The first cycle after rst deasserts SHALL fetch from RESET_PC.

Verification
REQ-024 Sequential fetch: rst then 3 free cycles, memory words A,B,C at 0,4,8 -> ifid_instr A,B,C; ifid_pc4 4,8,12; fetch_count 3; imem_addr 12.
REQ-025 Stall then redirect: PC=8, stall=1 for 2 cycles -> IF/ID and count frozen; then stall=1 with br_taken=1 and br_target=40 -> ifid_valid=0 and imem_addr=40 next cycle.
REQ-026 Priority: jmp=1 with jmp_target=100 and br_taken=1 with br_target=60 in the same cycle -> imem_addr=100 and ifid_valid=0.
REQ-027 Misaligned target: jmp_target=0x22 -> misalign_err=1, halted=1, ifid_valid=0; later jmp inputs ignored; rst clears both flags and PC returns to 0.
REQ-028 End of memory: PC=392, MEM_BYTES=400, no stall -> word at 392 delivered with ifid_pc4=396 and PC<=396; next cycle word at 396 delivered with ifid_pc4=400 and halted=1; the following cycle ifid_valid=0.
REQ-029 Saturation: fetch_count preset to 16'hFFFE then 3 sequential fetches -> fetch_count ends at 16'hFFFF.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with PC, redirect/stall handling and IF/ID pipeline register
module if_fetch_stage #(
  parameter int          MEM_BYTES = 400,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [15:0] fetch_count
);
  typedef enum logic {RUN, HALT} state_t;
  localparam logic [31:0] LAST = 32'(MEM_BYTES - 4);
  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc4, tgt, instr_n, pc4_n;
  logic        redir, valid_n, err_n;
  logic [15:0] cnt_n;
  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign pc4       = pc + 32'd4;
  assign redir     = jmp | br_taken;
  assign tgt       = jmp ? jmp_target : br_target;
  // next state and next IF/ID contents: redirect beats stall beats sequential fetch
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = ifid_instr;
    pc4_n   = ifid_pc4;
    valid_n = ifid_valid;
    err_n   = misalign_err;
    cnt_n   = fetch_count;
    if (state == HALT) begin
      instr_n = NOP;
      valid_n = 1'b0;
    end else if (redir) begin
      instr_n = NOP;
      pc4_n   = 32'd0;
      valid_n = 1'b0;
      if (tgt[1:0] != 2'b00) begin
        err_n   = 1'b1;
        state_n = HALT;
      end else if (tgt > LAST) state_n = HALT;
      else pc_n = tgt;
    end else if (!stall) begin
      instr_n = imem_data;
      pc4_n   = pc4;
      valid_n = 1'b1;
      cnt_n   = fetch_count + {15'b0, ~&fetch_count};
      state_n = (pc4 > LAST) ? HALT : RUN;
      pc_n    = (pc4 > LAST) ? pc : pc4;
    end
  end
  // state, PC and IF/ID registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pc           <= RESET_PC;
      ifid_instr   <= NOP;
      ifid_pc4     <= 32'd0;
      ifid_valid   <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= 16'd0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      ifid_instr   <= instr_n;
      ifid_pc4     <= pc4_n;
      ifid_valid   <= valid_n;
      misalign_err <= err_n;
      fetch_count  <= cnt_n;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: vector table, corner sequences and random run against a reference model
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jmp;
  logic [31:0] br_target, jmp_target, imem_addr, imem_data, ifid_instr, ifid_pc4;
  logic        ifid_valid, halted, misalign_err;
  logic [15:0] fetch_count;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_halt, m_valid, m_err;
  logic [15:0] m_cnt;

  typedef struct {
    logic s, b; logic [31:0] bt; logic j; logic [31:0] jt;
    logic [31:0] addr, instr, pc4; logic v, h, e; logic [15:0] cnt;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [31:0] memword(input logic [31:0] i);
    return 32'h1357_0000 ^ (i * 32'h0101_0011);
  endfunction

  assign imem_data = (imem_addr < 32'd400) ? memword({2'b00, imem_addr[31:2]}) : 32'hDEAD_BEEF;

  if_fetch_stage #(.MEM_BYTES(400), .RESET_PC(32'h0), .NOP(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mstep(input logic r, s, b, input logic [31:0] bt, input logic j, input logic [31:0] jt);
    logic [31:0] t;
    if (r) begin
      m_pc = 32'h0; m_halt = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_err = 1'b0; m_cnt = 16'h0;
    end else if (m_halt) begin
      m_valid = 1'b0; m_instr = 32'h0;
    end else if (j || b) begin
      t = j ? jt : bt;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (t % 4 != 0) begin m_err = 1'b1; m_halt = 1'b1; end
      else if (t > 32'd396) m_halt = 1'b1;
      else m_pc = t;
    end else if (!s) begin
      m_instr = memword(m_pc / 4);
      m_pc4 = m_pc + 32'd4;
      m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_pc + 32'd4 > 32'd396) m_halt = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step(input logic r, s, b, input logic [31:0] bt, input logic j, input logic [31:0] jt);
    rst = r; stall = s; br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
    mstep(r, s, b, bt, j, jt);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".addr"},  imem_addr, m_pc);
    check({tag, ".instr"}, ifid_instr, m_instr);
    check({tag, ".pc4"},   ifid_pc4, m_pc4);
    check({tag, ".valid"}, 32'(ifid_valid), 32'(m_valid));
    check({tag, ".halt"},  32'(halted), 32'(m_halt));
    check({tag, ".err"},   32'(misalign_err), 32'(m_err));
    check({tag, ".cnt"},   32'(fetch_count), 32'(m_cnt));
  endtask

  initial begin
    int guard;
    logic [31:0] t;
    logic r, s, b, j;
    logic [31:0] bt, jt;
    tbl[0]  = '{1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   32'd4,   memword(32'd0),  32'd4,   1'b1, 1'b0, 1'b0, 16'd1};
    tbl[1]  = '{1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   32'd8,   memword(32'd1),  32'd8,   1'b1, 1'b0, 1'b0, 16'd2};
    tbl[2]  = '{1'b1, 1'b0, 32'd0,   1'b0, 32'd0,   32'd8,   memword(32'd1),  32'd8,   1'b1, 1'b0, 1'b0, 16'd2};
    tbl[3]  = '{1'b1, 1'b0, 32'd0,   1'b0, 32'd0,   32'd8,   memword(32'd1),  32'd8,   1'b1, 1'b0, 1'b0, 16'd2};
    tbl[4]  = '{1'b1, 1'b1, 32'd40,  1'b0, 32'd0,   32'd40,  32'd0,           32'd0,   1'b0, 1'b0, 1'b0, 16'd2};
    tbl[5]  = '{1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   32'd44,  memword(32'd10), 32'd44,  1'b1, 1'b0, 1'b0, 16'd3};
    tbl[6]  = '{1'b0, 1'b1, 32'd60,  1'b1, 32'd100, 32'd100, 32'd0,           32'd0,   1'b0, 1'b0, 1'b0, 16'd3};
    tbl[7]  = '{1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   32'd104, memword(32'd25), 32'd104, 1'b1, 1'b0, 1'b0, 16'd4};
    tbl[8]  = '{1'b0, 1'b1, 32'd396, 1'b0, 32'd0,   32'd396, 32'd0,           32'd0,   1'b0, 1'b0, 1'b0, 16'd4};
    tbl[9]  = '{1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   32'd396, memword(32'd99), 32'd400, 1'b1, 1'b1, 1'b0, 16'd5};
    tbl[10] = '{1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   32'd396, 32'd0,           32'd400, 1'b0, 1'b1, 1'b0, 16'd5};
    tbl[11] = '{1'b1, 1'b0, 32'd0,   1'b1, 32'd0,   32'd396, 32'd0,           32'd400, 1'b0, 1'b1, 1'b0, 16'd5};

    // reset with competing inputs asserted
    step(1'b1, 1'b1, 1'b1, 32'd60, 1'b1, 32'd100);
    check("rst.addr", imem_addr, 32'd0);
    check("rst.instr", ifid_instr, 32'd0);
    check("rst.pc4", ifid_pc4, 32'd0);
    check("rst.valid", 32'(ifid_valid), 32'd0);
    check("rst.halt", 32'(halted), 32'd0);
    check("rst.err", 32'(misalign_err), 32'd0);
    check("rst.cnt", 32'(fetch_count), 32'd0);

    // vector table
    for (int i = 0; i < 12; i++) begin
      step(1'b0, tbl[i].s, tbl[i].b, tbl[i].bt, tbl[i].j, tbl[i].jt);
      check($sformatf("tbl%0d.addr", i), imem_addr, tbl[i].addr);
      check($sformatf("tbl%0d.instr", i), ifid_instr, tbl[i].instr);
      check($sformatf("tbl%0d.pc4", i), ifid_pc4, tbl[i].pc4);
      check($sformatf("tbl%0d.valid", i), 32'(ifid_valid), 32'(tbl[i].v));
      check($sformatf("tbl%0d.halt", i), 32'(halted), 32'(tbl[i].h));
      check($sformatf("tbl%0d.err", i), 32'(misalign_err), 32'(tbl[i].e));
      check($sformatf("tbl%0d.cnt", i), 32'(fetch_count), 32'(tbl[i].cnt));
    end

    // three sequential fetches from reset
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      check($sformatf("seq%0d.instr", k), ifid_instr, memword(32'(k)));
      check($sformatf("seq%0d.pc4", k), ifid_pc4, 32'(4 * (k + 1)));
    end
    check("seq.cnt", 32'(fetch_count), 32'd3);
    check("seq.addr", imem_addr, 32'd12);

    // reset overrides stall and redirect in the same cycle
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'd200);
    check("rstov.addr", imem_addr, 32'd0);
    check("rstov.cnt", 32'(fetch_count), 32'd0);

    // end of memory
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd392);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("eom1.instr", ifid_instr, memword(32'd98));
    check("eom1.pc4", ifid_pc4, 32'd396);
    check("eom1.addr", imem_addr, 32'd396);
    check("eom1.halt", 32'(halted), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("eom2.instr", ifid_instr, memword(32'd99));
    check("eom2.pc4", ifid_pc4, 32'd400);
    check("eom2.halt", 32'(halted), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("eom3.valid", 32'(ifid_valid), 32'd0);

    // misaligned redirect, ignored inputs while halted, reset recovery
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h22);
    check("mis.err", 32'(misalign_err), 32'd1);
    check("mis.halt", 32'(halted), 32'd1);
    check("mis.valid", 32'(ifid_valid), 32'd0);
    check("mis.addr", imem_addr, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd8);
    check("mis.ign", imem_addr, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("mis.rst.err", 32'(misalign_err), 32'd0);
    check("mis.rst.halt", 32'(halted), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("mis.refetch", ifid_pc4, 32'd4);

    // aligned out-of-range redirect halts without the error flag
    step(1'b0, 1'b0, 1'b1, 32'd400, 1'b0, 32'd0);
    check("oor.halt", 32'(halted), 32'd1);
    check("oor.err", 32'(misalign_err), 32'd0);
    check("oor.addr", imem_addr, 32'd4);

    // random stimulus against the model
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      j = ($urandom_range(0, 11) == 0);
      bt = 32'd0;
      jt = 32'd0;
      for (int q = 0; q < 2; q++) begin
        case ($urandom_range(0, 5))
          0: t = 32'($urandom_range(0, 99)) * 4 + 32'($urandom_range(1, 3));
          1: t = 32'($urandom_range(100, 250)) * 4;
          default: t = 32'($urandom_range(0, 99)) * 4;
        endcase
        if (q == 0) bt = t; else jt = t;
      end
      step(r, s, b, bt, j, jt);
      check_model($sformatf("rnd%0d", n));
    end

    // drive fetch_count up to saturation without running off the end of memory
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 80000) begin
      if (m_pc == 32'd392) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
      else step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      guard++;
    end
    if (guard >= 80000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sat.budget: cycle budget expired, model count %h", m_cnt);
    end
    check("sat.pre", 32'(fetch_count), 32'hFFFE);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check("sat.cnt", 32'(fetch_count), 32'hFFFF);
    check_model("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
